// File: rtl/jtdd_rom_pkg.sv
// Shared definitions for the ROM slot: SDRAM bus geometry, fetch FSM
// encoding and the line-offset width helper.
package jtdd_rom_pkg;

    localparam int SDRAM_AW = 22;
    localparam int SDRAM_DW = 32;

    // Fetch FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // Number of address bits that select an item inside a 32-bit line
    function automatic int off_w(input int dw);
        return (dw == 16) ? 1 : 2;
    endfunction

endpackage

// File: rtl/jtdd_rom_line.sv
// One cache line: tag, 32-bit data and valid bit, with a combinational
// tag compare and an item mux selected by the line offset.
module jtdd_rom_line
    import jtdd_rom_pkg::*;
#(
    parameter int TW = 16,
    parameter int DW = 8,
    parameter int OW = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_i,
    input  logic                we_i,
    input  logic [TW-1:0]       wtag_i,
    input  logic [SDRAM_DW-1:0] wdata_i,
    input  logic [TW-1:0]       tag_i,
    input  logic [OW-1:0]       off_i,
    output logic                hit_o,
    output logic [DW-1:0]       item_o
);

    logic [TW-1:0]       tag_q,   tag_d;
    logic [SDRAM_DW-1:0] data_q,  data_d;
    logic                valid_q, valid_d;
    logic [DW-1:0]       item_s;

    // Next-state for line contents; a clear always wins so a fill that
    // lands while the ROM set is reloading is stored but stays invalid
    always_comb begin
        tag_d   = tag_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (we_i) begin
            tag_d  = wtag_i;
            data_d = wdata_i;
        end else begin
            tag_d  = tag_q;
            data_d = data_q;
        end
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (we_i) begin
            valid_d = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Line storage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            tag_q   <= tag_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Item select: lower offset picks the lower-addressed item of the word
    always_comb begin
        item_s = '0;
        for (int i = 0; i < SDRAM_DW / DW; i++) begin
            item_s = (off_i == OW'(i)) ? data_q[i*DW +: DW] : item_s;
        end
    end

    assign hit_o  = valid_q && (tag_q == tag_i);
    assign item_o = item_s;

endmodule

// File: rtl/jtdd_rom_slot.sv
// Single-consumer ROM responder: serves reads from a two-line cache and
// fetches 32-bit SDRAM words on a miss. The cache is invalidated while the
// ROM set is downloading.
module jtdd_rom_slot
    import jtdd_rom_pkg::*;
#(
    parameter int                    AW     = 18,
    parameter int                    DW     = 8,
    parameter logic [SDRAM_AW-1:0]   OFFSET = 22'h0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rom_cs,
    input  logic [AW-1:0]       rom_addr,
    output logic [DW-1:0]       rom_data,
    output logic                rom_ok,
    input  logic                downloading,
    output logic                sdram_req,
    output logic [SDRAM_AW-1:0] sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_dst,
    input  logic                data_rdy,
    input  logic [SDRAM_DW-1:0] data_read
);

    localparam int OW = off_w(DW);
    localparam int TW = AW - OW;

    logic [TW-1:0]       tag_s;
    logic [OW-1:0]       off_s;
    logic [SDRAM_AW-1:0] fetch_addr_s;
    logic                hit0_s, hit1_s, hit_s;
    logic [DW-1:0]       item0_s, item1_s;
    logic                fill_s, we0_s, we1_s;

    logic [1:0]          state_q, state_d;
    logic                vic_q,   vic_d;
    logic                req_q,   req_d;
    logic [SDRAM_AW-1:0] addr_q,  addr_d;
    logic [TW-1:0]       ftag_q,  ftag_d;
    logic                ok_q,    ok_d;
    logic [DW-1:0]       data_q,  data_d;

    assign tag_s        = rom_addr[AW-1:OW];
    assign off_s        = rom_addr[OW-1:0];
    assign fetch_addr_s = OFFSET + SDRAM_AW'({tag_s, 1'b0});
    assign hit_s        = rom_cs && !downloading && (hit0_s || hit1_s);
    assign fill_s       = (state_q == ST_WAIT) && data_rdy && data_dst;
    assign we0_s        = fill_s && !vic_q;
    assign we1_s        = fill_s && vic_q;

    jtdd_rom_line #(.TW(TW), .DW(DW), .OW(OW)) u_line0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (downloading),
        .we_i    (we0_s),
        .wtag_i  (ftag_q),
        .wdata_i (data_read),
        .tag_i   (tag_s),
        .off_i   (off_s),
        .hit_o   (hit0_s),
        .item_o  (item0_s)
    );

    jtdd_rom_line #(.TW(TW), .DW(DW), .OW(OW)) u_line1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (downloading),
        .we_i    (we1_s),
        .wtag_i  (ftag_q),
        .wdata_i (data_read),
        .tag_i   (tag_s),
        .off_i   (off_s),
        .hit_o   (hit1_s),
        .item_o  (item1_s)
    );

    // Fetch FSM: a started fetch always runs to its fill, whatever the
    // consumer does meanwhile; new addresses are judged only in IDLE
    always_comb begin
        state_d = state_q;
        vic_d   = vic_q;
        req_d   = req_q;
        addr_d  = addr_q;
        ftag_d  = ftag_q;
        case (state_q)
            ST_IDLE: begin
                if (rom_cs && !downloading && !(hit0_s || hit1_s)) begin
                    ftag_d  = tag_s;
                    addr_d  = fetch_addr_s;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (sdram_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (fill_s) begin
                    vic_d   = !vic_q;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output stage: hit detected this cycle becomes rom_ok next cycle
    always_comb begin
        ok_d   = hit_s;
        data_d = data_q;
        if (hit_s) begin
            data_d = hit0_s ? item0_s : item1_s;
        end else begin
            data_d = data_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vic_q   <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            ftag_q  <= '0;
            ok_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            vic_q   <= vic_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            ftag_q  <= ftag_d;
            ok_q    <= ok_d;
            data_q  <= data_d;
        end
    end

    assign rom_ok     = ok_q;
    assign rom_data   = data_q;
    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;

endmodule

// File: tb/tb_jtdd_rom_slot.sv
// Bench for jtdd_rom_slot: one DW=8 instance (OFFSET 22'h1_0000) and one
// DW=16 instance (OFFSET 0) on a shared data bus, separated by data_dst.
module tb_jtdd_rom_slot;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cs, ack, dst, ok, req;
    logic [17:0] addr [2];
    logic [21:0] saddr [2];
    logic [7:0]  data8;
    logic [15:0] data16;
    logic        dl, rdy;
    logic [31:0] rd;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    jtdd_rom_slot #(.AW(18), .DW(8), .OFFSET(22'h1_0000)) u8 (
        .clk(clk), .rst_n(rst_n), .rom_cs(cs[0]), .rom_addr(addr[0]),
        .rom_data(data8), .rom_ok(ok[0]), .downloading(dl),
        .sdram_req(req[0]), .sdram_addr(saddr[0]), .sdram_ack(ack[0]),
        .data_dst(dst[0]), .data_rdy(rdy), .data_read(rd)
    );

    jtdd_rom_slot #(.AW(18), .DW(16), .OFFSET(22'h0)) u16 (
        .clk(clk), .rst_n(rst_n), .rom_cs(cs[1]), .rom_addr(addr[1]),
        .rom_data(data16), .rom_ok(ok[1]), .downloading(dl),
        .sdram_req(req[1]), .sdram_addr(saddr[1]), .sdram_ack(ack[1]),
        .data_dst(dst[1]), .data_rdy(rdy), .data_read(rd)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // SDRAM content model; word at 22'h1_0002 is 32'h44332211
    function automatic logic [31:0] word(input logic [21:0] a);
        logic [7:0] b;
        b = a[7:0] ^ 8'h02;
        return 32'h4433_2211 ^ {b, b, b, b};
    endfunction

    function automatic logic [21:0] fetch_addr(input int s, input logic [17:0] a);
        if (s == 0) return 22'h1_0000 + {5'h0, a[17:2], 1'b0};
        else        return {4'h0, a[17:1], 1'b0};
    endfunction

    // Consumer read with an SDRAM responder; expected item goes to the
    // scoreboard when the address is driven, compared when rom_ok shows up
    task automatic read(input int s, input logic [17:0] a, input logic exp_fetch, input string nm);
        logic [21:0] ea;
        logic [31:0] w;
        logic [15:0] got;
        logic acked, bogus, filled, done, fetched;
        int rdy_n;
        ea = fetch_addr(s, a);
        w  = word(ea);
        if (s == 0) exp_q.push_back({8'h0, w[int'(a[1:0])*8 +: 8]});
        else        exp_q.push_back(w[int'(a[0])*16 +: 16]);
        acked = 0; bogus = 0; filled = 0; done = 0; fetched = 0; rdy_n = -1;
        cs[s]   = 1'b1;
        addr[s] = a;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            ack[s] = 1'b0; rdy = 1'b0; dst = 2'b00;
            if (ok[s]) begin
                got = (s == 0) ? {8'h0, data8} : data16;
                chk({nm, "_data"}, {16'h0, got}, {16'h0, exp_q.pop_front()});
                chk({nm, "_lat"}, n, (rdy_n < 0) ? 0 : rdy_n + 2);
                done = 1;
            end else if (req[s] && !acked) begin
                chk({nm, "_saddr"}, {10'h0, saddr[s]}, {10'h0, ea});
                chk({nm, "_req_lat"}, n, 0);
                ack[s] = 1'b1; acked = 1; fetched = 1;
            end else if (acked && !bogus && !req[s]) begin
                // stray ack and data for another slot: both must be ignored
                ack[s] = 1'b1; rdy = 1'b1; dst = 2'b00; rd = ~w; bogus = 1;
            end else if (bogus && !filled) begin
                rdy = 1'b1; dst[s] = 1'b1; rd = w; filled = 1; rdy_n = n;
            end
        end
        if (!done) begin
            chk({nm, "_timeout"}, 0, 1);
            void'(exp_q.pop_front());
        end
        chk({nm, "_fetch"}, fetched, exp_fetch);
    endtask

    // Wait (bounded) for sdram_req, then acknowledge it; returns in WAIT
    task automatic req_ack(input int s, input logic [21:0] ea, input string nm);
        for (int n = 0; n < 10 && !req[s]; n++) @(negedge clk);
        chk({nm, "_req"}, req[s], 1);
        chk({nm, "_saddr"}, {10'h0, saddr[s]}, {10'h0, ea});
        ack[s] = 1'b1;
        @(negedge clk);
        ack[s] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cs = 2'b11; dl = 1'b1; ack = 2'b00; dst = 2'b00;
        rdy = 1'b0; rd = 32'h0; addr[0] = 18'h5; addr[1] = 18'h20;

        // 1: reset with request and downloading asserted
        repeat (3) begin
            @(negedge clk);
            chk("rst_req", {30'h0, req}, 32'h0);
            chk("rst_ok", {30'h0, ok}, 32'h0);
            chk("rst_data8", {24'h0, data8}, 32'h0);
            chk("rst_saddr", {10'h0, saddr[0]}, 32'h0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("dl_req", {30'h0, req}, 32'h0);
            chk("dl_ok", {30'h0, ok}, 32'h0);
        end
        dl = 1'b0; cs = 2'b00;
        @(negedge clk);

        // 2/3: cold miss then hits in the same line (DW=8)
        read(0, 18'h00005, 1'b1, "t2_miss");
        read(0, 18'h00006, 1'b0, "t3_hit6");
        read(0, 18'h00007, 1'b0, "t3_hit7");
        chk("t3_const", {24'h0, data8}, 32'h44);
        cs[0] = 1'b0;
        @(negedge clk);
        chk("cs_fall_ok", {31'h0, ok[0]}, 32'h0);

        // 4: two-line retention and victim rotation (DW=16)
        read(1, 18'h00020, 1'b1, "t4_A");
        read(1, 18'h00041, 1'b1, "t4_B");
        read(1, 18'h00021, 1'b0, "t4_A_hit");
        read(1, 18'h00060, 1'b1, "t4_C");
        read(1, 18'h00040, 1'b0, "t4_B_hit");
        read(1, 18'h00020, 1'b1, "t4_A_gone");
        cs[1] = 1'b0;
        @(negedge clk);

        // 5: rom_cs dropped during WAIT; the fill still lands
        cs[0] = 1'b1; addr[0] = 18'h00100;
        req_ack(0, 22'h1_0080, "t5");
        cs[0] = 1'b0;
        @(negedge clk);
        rdy = 1'b1; dst = 2'b01; rd = word(22'h1_0080);
        @(negedge clk);
        rdy = 1'b0; dst = 2'b00;
        repeat (3) begin
            @(negedge clk);
            chk("t5_ok_low", {31'h0, ok[0]}, 32'h0);
            chk("t5_req_low", {31'h0, req[0]}, 32'h0);
        end
        read(0, 18'h00100, 1'b0, "t5_rehit");

        // 6: downloading during WAIT discards the fill
        addr[0] = 18'h00200;
        req_ack(0, 22'h1_0100, "t6");
        dl = 1'b1;
        @(negedge clk);
        rdy = 1'b1; dst = 2'b01; rd = word(22'h1_0100);
        @(negedge clk);
        rdy = 1'b0; dst = 2'b00;
        repeat (4) begin
            @(negedge clk);
            chk("t6_req_low", {31'h0, req[0]}, 32'h0);
            chk("t6_ok_low", {31'h0, ok[0]}, 32'h0);
        end
        dl = 1'b0;
        read(0, 18'h00200, 1'b1, "t6_refetch");
        read(0, 18'h00100, 1'b1, "t6_flushed");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtdd_rom_slot.md
# jtdd_rom_slot

Single-consumer ROM responder sitting between one game-side ROM port (`rom_cs`/`rom_addr` in, `rom_data`/`rom_ok` out) and the shared SDRAM request bus. It answers reads from a two-line cache and fetches 32-bit SDRAM words on a miss. It invalidates the cache while the ROM set is downloading. One instance serves one ROM region, such as main CPU, sound, MCU or ADPCM.

## Interface
Parameters:
- `AW`, 18, consumer address width (units of `DW`).
- `DW`, 8, consumer data width; legal values are 8 and 16.
- `OFFSET`, 22'h0, SDRAM base, in 16-bit word units.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rom_cs`  in  1  consumer read request; level-sensitive.
- `rom_addr`  in  AW  consumer address.
- `rom_data`  out  DW  read data; valid while `rom_ok`=1.
- `rom_ok`  out  1  `rom_data` matches the current `rom_addr`.
- `downloading`  in  1  ROM set is being loaded; SDRAM is not servicing reads.
- `sdram_req`  out  1  fetch request; held until acknowledged.
- `sdram_addr`  out  22  fetch address, 16-bit word units, always even.
- `sdram_ack`  in  1  one-cycle pulse: the request was accepted.
- `data_dst`  in  1  `data_read` is addressed to this slot.
- `data_rdy`  in  1  `data_read` is valid this cycle.
- `data_read`  in  32  fetched word; the lower-addressed byte or halfword is in bits [7:0] / [15:0].

## Operation
- **Line format**: one 32-bit line holds 4 items (DW=8) or 2 items (DW=16).
  - Line offset: `rom_addr[1:0]` (DW=8) or `rom_addr[0]` (DW=16).
  - Tag: the remaining upper bits.
- **Cache**: two lines, each with tag, 32-bit data and a valid bit.
  - Victim pointer `vic` toggles after every fill.
- **Fetch address**: `sdram_addr = OFFSET + {tag, 1'b0}`, computed 22-bit, modulo 2^22.
- **FSM states**: IDLE, REQ, WAIT.
  - IDLE: if `rom_cs`=1, `downloading`=0 and there is no hit, latch the tag, set `sdram_req`=1 and go to REQ.
  - REQ: hold `sdram_req`/`sdram_addr` stable. On `sdram_ack`, drop `sdram_req` and go to WAIT.
  - WAIT: on `data_rdy & data_dst`, write `data_read` into line `vic`, set it valid, toggle `vic`, go to IDLE.
- **Hit rule**: `rom_cs`=1, the tag matches a valid line, and `downloading`=0.
- **Address change mid-fetch**: the in-flight fetch completes and fills its line. The new address is evaluated in IDLE afterwards. No fetch is ever aborted.
- **`rom_cs` dropped mid-fetch**: the fetch completes and the line fills; `rom_ok` stays 0.
- **`downloading`=1**:
  - Both valid bits are cleared every cycle and `rom_ok` is forced to 0.
  - In IDLE no new request is issued.
  - A request already in REQ/WAIT finishes, but its fill is written with valid=0.
- **Reset values**:
  - `rom_ok`=0, `rom_data`=0, `sdram_req`=0, `sdram_addr`=0.
  - Valid bits 0, `vic`=0, state IDLE.

## Timing
- `rom_data`/`rom_ok` are registered.
- **Hit latency**: the hit is detected in cycle N; `rom_ok`=1 with correct data at N+1.
- **`rom_ok` falls**:
  - on the cycle after `rom_addr` changes to a missing address, or
  - on the cycle after `rom_cs` falls.
- **Miss latency**:
  - `sdram_req` rises 1 cycle after the miss is seen.
  - The line is written on the `data_rdy` cycle; `rom_ok` rises 2 cycles after `data_rdy` (hit re-detected, then registered).
- **Ignored inputs**:
  - `data_rdy` with `data_dst`=0 is ignored.
  - `sdram_ack` outside REQ is ignored.
- **Simultaneous events**: when a fill and a hit on the other line occur in the same cycle, both are served with no stall.

## Structure
- Shared package `jtdd_rom_pkg`: FSM state enum (IDLE, REQ, WAIT), SDRAM address width (22) and SDRAM data width (32).
- One natural sub-module, `jtdd_rom_line`: tag/data/valid storage for one line, with a hit output and an item mux. It is instantiated twice.

## Test plan
1. **Reset and downloading**: hold `rst_n`=0 with `rom_cs`=1 and `downloading`=1 -> `sdram_req`=0 and `rom_ok`=0 throughout.
2. **Cold miss (DW=8, OFFSET=22'h1_0000)**: `rom_addr`=18'h00005 -> `sdram_addr`=22'h1_0002. Return `data_read`=32'h44332211 -> `rom_data`=8'h22, `rom_ok`=1 two cycles after `data_rdy`.
3. **Hit after fill**: step to `rom_addr`=18'h00006, then 18'h00007 -> no `sdram_req`; `rom_data`=8'h33 then 8'h44, one cycle each.
4. **Two-line retention (DW=16)**: fill tags A and B, then access A -> hit with no fetch. A third tag C replaces A (vic=0), and the next access to B still hits.
5. **Abandoned request**: `rom_cs` falls while in WAIT -> the fill completes and `rom_ok` stays 0. `rom_cs` then rises on the same address -> `rom_ok` at +1 cycle with no new request.
6. **Mid-fetch download**: `downloading` rises while in WAIT -> the fill is discarded (valid=0) and no request is made while `downloading`=1. After it falls, the same address refetches.
